fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequences the multicycle core's instruction fetch: owns the program counter, drives the combinational instruction memory address, and captures `{pc, instruction}` pairs into a small buffer feeding decode through a valid/ready handshake. Sits between the instruction memory and the decode/control stage. Supports start/halt control and a single-cycle redirect (branch/jump) that flushes buffered work.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `DEPTH`, 2: buffer entries; power of two, ≥2.

- `clk`  in  1: single clock, all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin fetching from the current PC; sampled in IDLE only.
- `halt`  in  1: stop issuing fetches, drain the buffer, return to IDLE.
- `redirect`  in  1: replace the PC and flush the buffer.
- `redirect_pc`  in  32: new PC; bits [1:0] are forced to 0.
- `imem_address`  out  32: equals the PC register; instruction memory reads combinationally.
- `imem_instruction`  in  32: memory data for `imem_address`, valid in the same cycle.
- `out_valid`  out  1: buffer head is valid.
- `out_ready`  in  1: decode accepts the head this cycle.
- `out_instruction`  out  32: instruction at the buffer head.
- `out_pc`  out  32: PC of the head instruction.
- `busy`  out  1: state is not IDLE.

## Operation
- States: IDLE, RUN, DRAIN.
- Reset: state=IDLE; PC=RESET_PC; buffer empty; `out_valid`=0, `out_instruction`=0, `out_pc`=0, `busy`=0.
- IDLE:
  - `start` → RUN. If `start` and `halt` are both high, `halt` wins and the state stays IDLE.
  - No captures occur.
- RUN:
  - Capture condition: `count<DEPTH` or a pop happens this cycle (`out_valid & out_ready`).
  - On capture, push `{PC, imem_instruction}` and set PC += 4. The add is mod 2^32, so 32'hFFFF_FFFC wraps to 0.
  - When the buffer is full and there is no pop, PC holds.
  - `halt` → DRAIN. No capture occurs in the `halt` cycle.
- DRAIN:
  - No captures; pops continue.
  - → IDLE when the buffer becomes empty: count==0, or count==1 with a pop this cycle.
- Redirect has top priority in every state:
  - Buffer is flushed (count=0, including any pop that cycle); PC=`{redirect_pc[31:2],2'b00}`; no capture that cycle.
  - RUN stays RUN. DRAIN goes to IDLE. IDLE stays IDLE with the new PC.
  - A `halt` in the same cycle as `redirect`: state goes to IDLE if it was RUN, and the PC is still updated.
- Pop: when `out_valid & out_ready`, the head is removed. A push and a pop in the same cycle leave count unchanged.
- `out_instruction`/`out_pc` keep their last head value when empty; decode must qualify them with `out_valid`.

## Timing
- Fetch latency: PC presented in cycle N is captured at the end of N; `out_valid` is high in N+1.
- Throughput: 1 instruction/cycle with `out_ready` held high.
- Redirect asserted in cycle N:
  - `imem_address`=redirect_pc in N+1.
  - That instruction appears at the head in N+2.
  - `out_valid`=0 in N+1.
- Start in cycle N (IDLE): RUN in N+1; first capture at the end of N+1.
- Halt in cycle N (RUN): no capture at N; DRAIN from N+1 until the cycle after the last pop.
- Outputs are registered or derived from registers only. `out_valid` does not depend combinationally on `out_ready`.
- Reset asserted mid-operation: all state returns to reset values on the next edge; in-flight entries are discarded.

## Structure
- Package `fetch_pkg`:
  - State enum `fetch_state_t` {IDLE, RUN, DRAIN}.
  - `PC_STEP`=4.
  - Entry struct `{pc[31:0], instr[31:0]}`.
- Sub-module `fetch_buffer`: synchronous FIFO of `DEPTH` 64-bit entries.
  - Ports: push, pop, flush, full, empty, count.
  - Flush overrides push and pop.
- Top level holds the FSM, the PC register and the capture/redirect priority logic.

## Test plan
- **Reset and start:** reset, `start` for 1 cycle, `out_ready`=1, memory returns `{addr}` as data → heads 0x0,0x4,0x8 with matching instructions on consecutive cycles; `busy`=1 from the cycle after `start`.
- **Backpressure:** `out_ready`=0 for 5 cycles → count saturates at 2 (heads 0x0, 0x4), `imem_address` holds 0x8; release → 0x8 follows 0x4 with no gap or duplicate.
- **Redirect:** redirect to 0x103 while 2 entries are buffered → `out_valid`=0 next cycle; head `out_pc`=0x100 two cycles after the redirect.
- **Halt drain:** `halt` with 2 entries buffered and `out_ready`=1 → 2 pops, then IDLE; `busy`=0; `imem_address` frozen at the next unfetched PC.
- **Wrap and reset priority:** redirect to 0xFFFF_FFF8 → PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- **Simultaneous events:** `start`+`halt` in IDLE stays IDLE; `halt`+`redirect` in RUN goes to IDLE with PC=redirect_pc; `reset` mid-RUN → `out_valid`=0, PC=RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller.
//   fetch_state_t : controller FSM states
//   PC_STEP       : byte increment between sequential fetches
//   fetch_entry_t : one buffered {pc, instruction} pair
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched {pc, instruction} entries.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   push, wdata    : enqueue an entry (ignored when full without a pop)
//   pop            : dequeue the head (ignored when empty)
//   flush          : drop all entries; overrides push and pop
//   rdata          : registered head entry; holds its last value when empty
//   full, empty    : occupancy flags
//   count          : number of valid entries
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       wdata,
  output fetch_entry_t       rdata,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t             mem_q [DEPTH];
  fetch_entry_t             head_q, head_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = head_q;

  // Pointer/count update; the head register is refreshed with the entry that
  // will sit at the read pointer after this edge, bypassing a same-cycle write.
  always_comb begin
    do_pop   = pop & ~empty & ~flush;
    do_push  = push & ~flush & (~full | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (count_d != '0) begin
        head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? wdata : mem_q[rd_ptr_d];
      end
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are only observed through count-qualified reads
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, addresses the combinational
// instruction memory and buffers {pc, instruction} pairs toward decode.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   start, halt                    : begin fetching / stop and drain
//   redirect, redirect_pc          : load a new PC and flush buffered work
//   imem_address, imem_instruction : instruction memory read port
//   out_valid, out_ready           : decode handshake
//   out_instruction, out_pc        : buffer head payload
//   busy                           : FSM not in IDLE
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              push, pop, flush;
  logic              full, empty;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      wdata, head;

  assign out_valid       = ~empty;
  assign pop             = out_valid & out_ready;
  assign imem_address    = pc_q;
  assign out_pc          = head.pc;
  assign out_instruction = head.instr;
  assign busy            = (state_q != IDLE);
  assign wdata           = '{pc: pc_q, instr: imem_instruction};

  fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Next state, PC and capture; redirect outranks every other event
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect) begin
      flush = 1'b1;
      pc_d  = redirect_pc & ~32'h0000_0003;
      case (state_q)
        RUN:     state_d = halt ? IDLE : RUN;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !halt) state_d = RUN;
        end
        RUN: begin
          if (halt) begin
            state_d = DRAIN;
          end else if (!full || pop) begin
            push = 1'b1;
            pc_d = pc_q + PC_STEP;
          end
        end
        DRAIN: begin
          if (empty || ((count == CNT_W'(1)) && pop)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios with a
// scoreboard of expected head PCs popped on every accepted handshake.
module tb_fetch_controller;

  localparam logic [31:0] MEM_KEY = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        busy;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  // Instruction memory model: data is a keyed function of the address
  assign imem_instruction = imem_address ^ MEM_KEY;

  fetch_controller #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .halt             (halt),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .busy             (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted head must match the next expected PC
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_pop", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check_eq("head_pc", out_pc, e);
        check_eq("head_instr", out_instruction, e ^ MEM_KEY);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0;
    redirect_pc = '0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_addr", imem_address, 32'h0);
    check_eq("rst_out_pc", out_pc, 32'h0);
    check_eq("rst_out_instr", out_instruction, 32'h0);

    // Start with decode always ready: heads 0x0, 0x4, 0x8 back to back
    start = 1'b1; out_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    step();
    start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_valid_lat", 32'(out_valid), 32'd0);
    check_eq("start_addr", imem_address, 32'h0);
    step();
    check_eq("first_valid", 32'(out_valid), 32'd1);
    check_eq("first_pc", out_pc, 32'h0);
    check_eq("first_addr_next", imem_address, 32'h4);
    step();
    step();
    check_eq("third_pc", out_pc, 32'h8);
    step();
    out_ready = 1'b0;
    reset = 1'b1;
    check_eq("t1_sb_drained", 32'(exp_q.size()), 32'd0);
    step();
    reset = 1'b0;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_addr", imem_address, 32'h0);
    check_eq("midrst_busy", 32'(busy), 32'd0);

    // Backpressure: buffer fills with 0x0,0x4 and the PC holds at 0x8
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    check_eq("bp_addr_hold", imem_address, 32'h8);
    check_eq("bp_head_pc", out_pc, 32'h0);
    check_eq("bp_valid", 32'(out_valid), 32'd1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    out_ready = 1'b1;
    step(); step(); step(); step();
    check_eq("bp_sb_drained", 32'(exp_q.size()), 32'd0);
    check_eq("bp_steady_addr", imem_address, 32'h18);

    // Redirect to an unaligned target with two entries buffered
    out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    exp_q.push_back(32'h100);
    step();
    redirect = 1'b0;
    check_eq("redir_valid_flushed", 32'(out_valid), 32'd0);
    check_eq("redir_addr", imem_address, 32'h100);
    out_ready = 1'b1;
    step();
    check_eq("redir_head_valid", 32'(out_valid), 32'd1);
    check_eq("redir_head_pc", out_pc, 32'h100);
    step();
    out_ready = 1'b0;
    step();

    // Halt with two entries (0x104, 0x108) buffered and decode ready
    check_eq("halt_pre_addr", imem_address, 32'h10C);
    halt = 1'b1; out_ready = 1'b1;
    exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    step();
    halt = 1'b0;
    check_eq("drain_busy", 32'(busy), 32'd1);
    step();
    check_eq("halt_idle_busy", 32'(busy), 32'd0);
    check_eq("halt_idle_valid", 32'(out_valid), 32'd0);
    check_eq("halt_frozen_addr", imem_address, 32'h10C);
    check_eq("halt_head_hold", out_pc, 32'h108);
    check_eq("halt_sb_drained", 32'(exp_q.size()), 32'd0);

    // PC wrap: redirect in IDLE to 0xFFFF_FFF8, then run across zero
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    check_eq("idle_redir_busy", 32'(busy), 32'd0);
    check_eq("idle_redir_addr", imem_address, 32'hFFFF_FFF8);
    start = 1'b1;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    step();
    start = 1'b0;
    step();
    step();
    check_eq("wrap_addr_zero", imem_address, 32'h0);
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    step();
    check_eq("wrap_idle_busy", 32'(busy), 32'd0);
    check_eq("wrap_next_addr", imem_address, 32'h4);
    check_eq("wrap_sb_drained", 32'(exp_q.size()), 32'd0);

    // Simultaneous events: start+halt in IDLE, then halt+redirect in RUN
    out_ready = 1'b0; start = 1'b1; halt = 1'b1;
    step();
    halt = 1'b0;
    check_eq("start_halt_idle", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    check_eq("restart_busy", 32'(busy), 32'd1);
    step();
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    halt = 1'b0; redirect = 1'b0;
    check_eq("halt_redir_busy", 32'(busy), 32'd0);
    check_eq("halt_redir_addr", imem_address, 32'h200);
    check_eq("halt_redir_valid", 32'(out_valid), 32'd0);
    step();
    check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
